// File: rtl/bus_arbiter.sv
// Two-port arbiter sharing one fixed-latency memory bus between the CPU (port 0) and an auxiliary master (port 1).
// Contention policy: fixed priority to port 0 by default; `BUS_ARBITER_ROUND_ROBIN_EN selects round-robin.
module bus_arbiter #(
    parameter int BUS_ADDRESS_WIDTH = 32,
    parameter int BUS_DATA_WIDTH    = 32,
    parameter int READ_LATENCY      = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         request_0,
    input  logic                         request_1,
    input  logic                         lock_0,
    input  logic                         lock_1,
    input  logic                         write_enable_0,
    input  logic                         write_enable_1,
    input  logic [BUS_ADDRESS_WIDTH-1:0] address_0,
    input  logic [BUS_ADDRESS_WIDTH-1:0] address_1,
    input  logic [BUS_DATA_WIDTH-1:0]    write_data_0,
    input  logic [BUS_DATA_WIDTH-1:0]    write_data_1,
    output logic                         grant_0,
    output logic                         grant_1,
    output logic                         read_valid_0,
    output logic                         read_valid_1,
    output logic [BUS_DATA_WIDTH-1:0]    read_data_out,
    output logic [BUS_ADDRESS_WIDTH-1:0] address,
    output logic                         write_enable,
    output logic [BUS_DATA_WIDTH-1:0]    write_data,
    input  logic [BUS_DATA_WIDTH-1:0]    read_data
);

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_0    = 2'd1,
        LOCK_1    = 2'd2
    } lock_t;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    lock_t                   r_lock_owner;
    logic                    r_last_winner;
    logic [READ_LATENCY-1:0] r_tag_valid;
    logic [READ_LATENCY-1:0] r_tag_id;

    logic w_grant_0;
    logic w_grant_1;
    logic w_any_grant;
    logic w_winner;
    logic w_granted_lock;
    logic w_granted_we;
    logic w_contend_pick_1;

    // last_winner is always tracked; it only steers contention in the round-robin build.
    assign w_contend_pick_1 = ROUND_ROBIN && !r_last_winner;

    always_comb begin
        w_grant_0 = 1'b0;
        w_grant_1 = 1'b0;
        case (r_lock_owner)
            LOCK_0:  w_grant_0 = request_0;
            LOCK_1:  w_grant_1 = request_1;
            default: begin
                if (request_0 && request_1) begin
                    w_grant_0 = !w_contend_pick_1;
                    w_grant_1 = w_contend_pick_1;
                end else begin
                    w_grant_0 = request_0;
                    w_grant_1 = request_1;
                end
            end
        endcase
    end

    assign w_any_grant    = w_grant_0 || w_grant_1;
    assign w_winner       = w_grant_1;
    assign w_granted_lock = w_grant_1 ? lock_1 : lock_0;
    assign w_granted_we   = w_grant_1 ? write_enable_1 : write_enable_0;

    assign grant_0 = w_grant_0;
    assign grant_1 = w_grant_1;

    always_comb begin
        address      = '0;
        write_data   = '0;
        write_enable = 1'b0;
        if (w_grant_0) begin
            address      = address_0;
            write_data   = write_data_0;
            write_enable = write_enable_0;
        end else if (w_grant_1) begin
            address      = address_1;
            write_data   = write_data_1;
            write_enable = write_enable_1;
        end
    end

    // While a lock is held only the owner can be granted, so any unlocked grant releases it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_winner <= 1'b1;
            r_lock_owner  <= LOCK_NONE;
            r_tag_valid   <= '0;
            r_tag_id      <= '0;
        end else begin
            if (w_any_grant) begin
                r_last_winner <= w_winner;
                if (w_granted_lock) begin
                    r_lock_owner <= w_winner ? LOCK_1 : LOCK_0;
                end else begin
                    r_lock_owner <= LOCK_NONE;
                end
            end
            r_tag_valid[0] <= w_any_grant && !w_granted_we;
            r_tag_id[0]    <= w_winner;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_id[i]    <= r_tag_id[i-1];
            end
        end
    end

    assign read_valid_0  = r_tag_valid[READ_LATENCY-1] && !r_tag_id[READ_LATENCY-1];
    assign read_valid_1  = r_tag_valid[READ_LATENCY-1] &&  r_tag_id[READ_LATENCY-1];
    assign read_data_out = read_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: three instances (READ_LATENCY 1, 2, 3) share one stimulus stream.
// Contention expectations follow `BUS_ARBITER_ROUND_ROBIN_EN when it is defined.
module tb_bus_arbiter;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        request_0, request_1, lock_0, lock_1, write_enable_0, write_enable_1;
    logic [31:0] address_0, address_1, write_data_0, write_data_1, read_data;

    logic        o1_g0, o1_g1, o1_rv0, o1_rv1, o1_we;
    logic [31:0] o1_rdo, o1_addr, o1_wd;
    logic        o2_g0, o2_g1, o2_rv0, o2_rv1, o2_we;
    logic [31:0] o2_rdo, o2_addr, o2_wd;
    logic        o3_g0, o3_g1, o3_rv0, o3_rv1, o3_we;
    logic [31:0] o3_rdo, o3_addr, o3_wd;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(.READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .request_0(request_0), .request_1(request_1), .lock_0(lock_0), .lock_1(lock_1),
        .write_enable_0(write_enable_0), .write_enable_1(write_enable_1),
        .address_0(address_0), .address_1(address_1),
        .write_data_0(write_data_0), .write_data_1(write_data_1),
        .grant_0(o1_g0), .grant_1(o1_g1), .read_valid_0(o1_rv0), .read_valid_1(o1_rv1),
        .read_data_out(o1_rdo), .address(o1_addr), .write_enable(o1_we), .write_data(o1_wd),
        .read_data(read_data)
    );

    bus_arbiter #(.READ_LATENCY(2)) dut2 (
        .clock(clock), .reset(reset),
        .request_0(request_0), .request_1(request_1), .lock_0(lock_0), .lock_1(lock_1),
        .write_enable_0(write_enable_0), .write_enable_1(write_enable_1),
        .address_0(address_0), .address_1(address_1),
        .write_data_0(write_data_0), .write_data_1(write_data_1),
        .grant_0(o2_g0), .grant_1(o2_g1), .read_valid_0(o2_rv0), .read_valid_1(o2_rv1),
        .read_data_out(o2_rdo), .address(o2_addr), .write_enable(o2_we), .write_data(o2_wd),
        .read_data(read_data)
    );

    bus_arbiter #(.READ_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset),
        .request_0(request_0), .request_1(request_1), .lock_0(lock_0), .lock_1(lock_1),
        .write_enable_0(write_enable_0), .write_enable_1(write_enable_1),
        .address_0(address_0), .address_1(address_1),
        .write_data_0(write_data_0), .write_data_1(write_data_1),
        .grant_0(o3_g0), .grant_1(o3_g1), .read_valid_0(o3_rv0), .read_valid_1(o3_rv1),
        .read_data_out(o3_rdo), .address(o3_addr), .write_enable(o3_we), .write_data(o3_wd),
        .read_data(read_data)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // driver tasks
    task automatic idle_inputs();
        request_0 = 0; request_1 = 0; lock_0 = 0; lock_1 = 0;
        write_enable_0 = 0; write_enable_1 = 0;
        address_0 = '0; address_1 = '0; write_data_0 = '0; write_data_1 = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic pad(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_g0;
        reset = 1'b1;
        read_data = '0;
        idle_inputs();
        tick();
        tick();

        // reset state
        reset = 1'b0;
        settle();
        chk("rst_g0", 32'(o1_g0), 32'd0);
        chk("rst_g1", 32'(o1_g1), 32'd0);
        chk("rst_rv0", 32'(o3_rv0), 32'd0);
        chk("rst_rv1", 32'(o3_rv1), 32'd0);
        chk("rst_addr", o1_addr, 32'd0);
        chk("rst_we", 32'(o1_we), 32'd0);
        chk("rst_wd", o1_wd, 32'd0);

        // single requester: port 1 read at 0x40, latency 1
        tick();
        request_1 = 1; address_1 = 32'h40;
        settle();
        chk("single_g1", 32'(o1_g1), 32'd1);
        chk("single_g0", 32'(o1_g0), 32'd0);
        chk("single_addr", o1_addr, 32'h40);
        chk("single_we", 32'(o1_we), 32'd0);
        tick();
        request_1 = 0; read_data = 32'hDEADBEEF;
        settle();
        chk("single_rv1", 32'(o1_rv1), 32'd1);
        chk("single_rv0", 32'(o1_rv0), 32'd0);
        chk("single_rdo", o1_rdo, 32'hDEADBEEF);
        pad(4);

        // continuous contention, both reading
        request_0 = 1; address_0 = 32'h100;
        request_1 = 1; address_1 = 32'h200;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            settle();
            exp_g0 = RR ? ((i % 2) == 0) : 1'b1;
            chk($sformatf("cont_g0_%0d", i), 32'(o1_g0), 32'(exp_g0));
            chk($sformatf("cont_g1_%0d", i), 32'(o1_g1), 32'(!exp_g0));
            chk($sformatf("cont_addr_%0d", i), o1_addr, exp_g0 ? 32'h100 : 32'h200);
            tick();
            #0;
            if (i < 3) begin
                // stay aligned: tick already advanced to next cycle
                i++;
                settle();
                exp_g0 = RR ? ((i % 2) == 0) : 1'b1;
                chk($sformatf("cont_g0_%0d", i), 32'(o1_g0), 32'(exp_g0));
                chk($sformatf("cont_g1_%0d", i), 32'(o1_g1), 32'(!exp_g0));
                chk($sformatf("cont_addr_%0d", i), o1_addr, exp_g0 ? 32'h100 : 32'h200);
            end
        end
        pad(4);

        // lock held by port 1 across idle cycles, released by an unlocked write
        request_1 = 1; write_enable_1 = 1; lock_1 = 1; address_1 = 32'h10; write_data_1 = 32'h11;
        settle();
        chk("lock_a_g1", 32'(o1_g1), 32'd1);
        chk("lock_a_g0", 32'(o1_g0), 32'd0);
        chk("lock_a_addr", o1_addr, 32'h10);
        chk("lock_a_we", 32'(o1_we), 32'd1);
        chk("lock_a_wd", o1_wd, 32'h11);
        tick();
        request_1 = 0;
        request_0 = 1; write_enable_0 = 1; address_0 = 32'h80; write_data_0 = 32'h22;
        settle();
        chk("lock_b_g0", 32'(o1_g0), 32'd0);
        chk("lock_b_addr", o1_addr, 32'd0);
        chk("lock_b_we", 32'(o1_we), 32'd0);
        tick();
        settle();
        chk("lock_c_g0", 32'(o1_g0), 32'd0);
        chk("lock_c_g1", 32'(o1_g1), 32'd0);
        tick();
        request_1 = 1; lock_1 = 0; address_1 = 32'h14; write_data_1 = 32'h33;
        settle();
        chk("lock_d_g1", 32'(o1_g1), 32'd1);
        chk("lock_d_g0", 32'(o1_g0), 32'd0);
        chk("lock_d_addr", o1_addr, 32'h14);
        tick();
        request_1 = 0;
        settle();
        chk("lock_e_g0", 32'(o1_g0), 32'd1);
        chk("lock_e_addr", o1_addr, 32'h80);
        chk("lock_e_wd", o1_wd, 32'h22);
        pad(4);

        // tagged pipeline: read p0, read p1, write p0, read p1
        request_0 = 1; address_0 = 32'h20;
        settle();
        chk("pipe_c0_g0", 32'(o3_g0), 32'd1);
        tick();
        request_0 = 0; request_1 = 1; address_1 = 32'h24; read_data = 32'h1111_0000;
        settle();
        chk("pipe_c1_l1_rv0", 32'(o1_rv0), 32'd1);
        chk("pipe_c1_l1_rdo", o1_rdo, 32'h1111_0000);
        tick();
        request_1 = 0; request_0 = 1; write_enable_0 = 1; address_0 = 32'h28; read_data = 32'h2222_0000;
        settle();
        chk("pipe_c2_l1_rv1", 32'(o1_rv1), 32'd1);
        chk("pipe_c2_l3_rv0", 32'(o3_rv0), 32'd0);
        tick();
        request_0 = 0; write_enable_0 = 0; request_1 = 1; address_1 = 32'h2C; read_data = 32'h3333_0000;
        settle();
        chk("pipe_c3_l1_rv0", 32'(o1_rv0), 32'd0);
        chk("pipe_c3_l1_rv1", 32'(o1_rv1), 32'd0);
        chk("pipe_c3_l3_rv0", 32'(o3_rv0), 32'd1);
        chk("pipe_c3_l3_rv1", 32'(o3_rv1), 32'd0);
        chk("pipe_c3_l3_rdo", o3_rdo, 32'h3333_0000);
        tick();
        request_1 = 0; read_data = 32'h4444_0000;
        settle();
        chk("pipe_c4_l1_rv1", 32'(o1_rv1), 32'd1);
        chk("pipe_c4_l3_rv1", 32'(o3_rv1), 32'd1);
        chk("pipe_c4_l3_rv0", 32'(o3_rv0), 32'd0);
        chk("pipe_c4_l3_rdo", o3_rdo, 32'h4444_0000);
        tick();
        read_data = 32'h5555_0000;
        settle();
        chk("pipe_c5_l3_rv0", 32'(o3_rv0), 32'd0);
        chk("pipe_c5_l3_rv1", 32'(o3_rv1), 32'd0);
        tick();
        read_data = 32'h6666_0000;
        settle();
        chk("pipe_c6_l3_rv1", 32'(o3_rv1), 32'd1);
        chk("pipe_c6_l3_rv0", 32'(o3_rv0), 32'd0);
        chk("pipe_c6_l3_rdo", o3_rdo, 32'h6666_0000);
        pad(4);

        // reset while a locked port-0 read is in flight
        request_0 = 1; lock_0 = 1; address_0 = 32'h30;
        settle();
        chk("rmid_c0_g0", 32'(o2_g0), 32'd1);
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("rmid_l2_rv0", 32'(o2_rv0), 32'd0);
        chk("rmid_l2_rv1", 32'(o2_rv1), 32'd0);
        chk("rmid_g0", 32'(o2_g0), 32'd0);
        chk("rmid_g1", 32'(o2_g1), 32'd0);
        chk("rmid_addr", o2_addr, 32'd0);
        chk("rmid_we", 32'(o2_we), 32'd0);
        chk("rmid_wd", o2_wd, 32'd0);
        tick();
        request_1 = 1; address_1 = 32'h60;
        settle();
        chk("rmid_l3_rv0", 32'(o3_rv0), 32'd0);
        chk("rmid_unlock_g1", 32'(o2_g1), 32'd1);
        chk("rmid_unlock_g0", 32'(o2_g0), 32'd0);
        tick();
        request_0 = 1; address_0 = 32'h64;
        settle();
        chk("rmid_cont_g0", 32'(o2_g0), 32'd1);
        chk("rmid_cont_g1", 32'(o2_g1), 32'd0);
        chk("rmid_cont_addr", o2_addr, 32'h64);
        pad(4);

        // idle bus
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("idle_g_%0d", i), {28'd0, o1_g0, o1_g1, o3_g0, o3_g1}, 32'd0);
            chk($sformatf("idle_rv_%0d", i), {28'd0, o1_rv0, o1_rv1, o3_rv0, o3_rv1}, 32'd0);
            chk($sformatf("idle_we_%0d", i), 32'(o1_we), 32'd0);
            chk($sformatf("idle_addr_%0d", i), o1_addr, 32'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
